// File: rtl/el2_pkg.sv
// Shared PMP types: cfg byte layout, Smepmp mseccfg fields, address modes and CSR addresses.
package el2_pkg;

   typedef enum logic [1:0] {
      PMP_OFF   = 2'd0,
      PMP_TOR   = 2'd1,
      PMP_NA4   = 2'd2,
      PMP_NAPOT = 2'd3
   } el2_pmp_mode_t;

   // Bit order matches the architectural pmpcfg byte: L, 2 reserved, A, X, W, R.
   typedef struct packed {
      logic          lock;
      logic [1:0]    rsvd;
      el2_pmp_mode_t mode;
      logic          execute;
      logic          write;
      logic          read;
   } el2_pmp_cfg_pkt_t;

   typedef struct packed {
      logic rlm;
      logic mmwp;
      logic mml;
   } el2_mseccfg_pkt_t;

   localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
   localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
   localparam logic [11:0] MSECCFG_ADDR = 12'h747;

endpackage

// File: rtl/el2_pmp_cfg_warl.sv
// Legalises one pmpcfg byte against lock state, reserved encodings and the Smepmp MML rules.
module el2_pmp_cfg_warl
   import el2_pkg::*;
#(
   parameter int PMP_GRANULARITY = 0
) (
   input  el2_pmp_cfg_pkt_t i_cfg,
   input  logic [7:0]       i_wbyte,
   input  logic             i_locked,
   input  logic             i_mml,
   input  logic             i_rlm,
   output el2_pmp_cfg_pkt_t o_cfg,
   output logic             o_drop
);

   el2_pmp_cfg_pkt_t w_new;
   logic             w_shared;

   always_comb begin
      w_new      = el2_pmp_cfg_pkt_t'(i_wbyte);
      w_new.rsvd = 2'b00;
      // R=0,W=1 is reserved normally but encodes a shared region under MML.
      w_shared   = ~w_new.read & w_new.write;
      o_drop     = i_locked
                 | (w_shared & ~i_mml)
                 | ((w_new.mode == PMP_NA4) && (PMP_GRANULARITY >= 1))
                 | (i_mml & ~i_rlm & w_new.lock & ((w_new.execute & ~w_shared) | w_shared));
      o_cfg      = o_drop ? i_cfg : w_new;
   end

endmodule

// File: rtl/el2_pmp_csr.sv
// PMP CSR file: pmpcfg/pmpaddr storage with WARL and lock legalisation, read mux, ignored flag.
// Define PMP_SMEPMP_EN to implement the Smepmp mseccfg register (otherwise tied to zero).
module el2_pmp_csr
   import el2_pkg::*;
#(
   parameter  int PMP_ENTRIES     = 16,
   parameter  int PMP_GRANULARITY = 0,
   localparam int NE              = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             csr_wr_en,
   input  logic [11:0]      csr_wr_addr,
   input  logic [31:0]      csr_wr_data,
   input  logic [11:0]      csr_rd_addr,
   output logic             csr_rd_hit,
   output logic [31:0]      csr_rd_data,
   output logic             csr_wr_ignored,
   output el2_pmp_cfg_pkt_t pmp_pmpcfg  [NE],
   output logic [31:0]      pmp_pmpaddr [NE],
   output el2_mseccfg_pkt_t mseccfg
);

   localparam logic [31:0] NAPOT_ONES = (PMP_GRANULARITY >= 1) ?
                                        (((32'h1 << PMP_GRANULARITY) >> 1) - 32'h1) : 32'h0;
   localparam logic [31:0] OFF_MASK   = (32'h1 << PMP_GRANULARITY) - 32'h1;

   el2_pmp_cfg_pkt_t r_cfg  [16];
   logic [31:0]      r_addr [16];
   logic             r_wr_ignored;
   el2_mseccfg_pkt_t w_mseccfg;
   logic             w_msec_drop;
   logic [15:0]      w_locked, w_lock_tor, w_cfg_sel, w_cfg_drop, w_addr_sel, w_addr_drop;
   logic [7:0]       w_wbyte   [16];
   el2_pmp_cfg_pkt_t w_cfg_new [16];
   logic             w_cfg_wr, w_addr_wr, w_ignored;

   function automatic logic [31:0] addr_view(input logic [31:0] a, input el2_pmp_mode_t m);
      case (m)
         PMP_NAPOT:       return a | NAPOT_ONES;
         PMP_OFF, PMP_TOR: return a & ~OFF_MASK;
         default:         return a;
      endcase
   endfunction

   assign w_cfg_wr  = csr_wr_en & (csr_wr_addr[11:2] == PMPCFG_BASE[11:2]);
   assign w_addr_wr = csr_wr_en & (csr_wr_addr[11:4] == PMPADDR_BASE[11:4]);

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         w_locked[i]   = r_cfg[i].lock & ~w_mseccfg.rlm;
         w_lock_tor[i] = w_locked[i] & (r_cfg[i].mode == PMP_TOR);
         w_wbyte[i]    = csr_wr_data[8*(i%4) +: 8];
         w_cfg_sel[i]  = w_cfg_wr & (csr_wr_addr[1:0] == 2'(i/4)) & (i < PMP_ENTRIES);
         w_addr_sel[i] = w_addr_wr & (csr_wr_addr[3:0] == 4'(i)) & (i < PMP_ENTRIES);
      end
      // A locked TOR entry also protects the base address held in the entry below it.
      for (int i = 0; i < 16; i++)
         w_addr_drop[i] = w_locked[i] | (w_lock_tor[(i+1)%16] & (i + 1 < PMP_ENTRIES));
   end

   for (genvar g = 0; g < 16; g++) begin : g_entry
      el2_pmp_cfg_warl #(.PMP_GRANULARITY(PMP_GRANULARITY)) u_warl (
         .i_cfg    (r_cfg[g]),
         .i_wbyte  (w_wbyte[g]),
         .i_locked (w_locked[g]),
         .i_mml    (w_mseccfg.mml),
         .i_rlm    (w_mseccfg.rlm),
         .o_cfg    (w_cfg_new[g]),
         .o_drop   (w_cfg_drop[g])
      );
   end

   assign w_ignored = (|(w_cfg_sel & w_cfg_drop)) | (|(w_addr_sel & w_addr_drop)) | w_msec_drop;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < 16; i++) begin
            r_cfg[i]  <= '0;
            r_addr[i] <= '0;
         end
         r_wr_ignored <= 1'b0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (w_cfg_sel[i])                  r_cfg[i]  <= w_cfg_new[i];
            if (w_addr_sel[i] & ~w_addr_drop[i]) r_addr[i] <= csr_wr_data;
         end
         r_wr_ignored <= w_ignored;
      end
   end

`ifdef PMP_SMEPMP_EN
   el2_mseccfg_pkt_t r_mseccfg;
   logic             w_any_lock, w_msec_wr;

   always_comb begin
      w_any_lock = 1'b0;
      for (int i = 0; i < 16; i++) w_any_lock |= r_cfg[i].lock;
   end

   assign w_msec_wr   = csr_wr_en & (csr_wr_addr == MSECCFG_ADDR);
   assign w_msec_drop = w_msec_wr & w_any_lock & ~r_mseccfg.rlm & csr_wr_data[2];

   // MML and MMWP are sticky once set; only reset clears them.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_mseccfg <= '0;
      end else if (w_msec_wr) begin
         r_mseccfg.mml  <= r_mseccfg.mml  | csr_wr_data[0];
         r_mseccfg.mmwp <= r_mseccfg.mmwp | csr_wr_data[1];
         if (!w_msec_drop) r_mseccfg.rlm <= csr_wr_data[2];
      end
   end

   assign w_mseccfg = r_mseccfg;
`else
   assign w_mseccfg   = '0;
   assign w_msec_drop = 1'b0;
`endif

   always_comb begin
      csr_rd_hit  = 1'b0;
      csr_rd_data = '0;
      if (csr_rd_addr[11:2] == PMPCFG_BASE[11:2]) begin
         csr_rd_hit = 1'b1;
         for (int j = 0; j < 4; j++)
            csr_rd_data[8*j +: 8] = r_cfg[{csr_rd_addr[1:0], 2'(j)}];
      end else if (csr_rd_addr[11:4] == PMPADDR_BASE[11:4]) begin
         csr_rd_hit  = 1'b1;
         csr_rd_data = addr_view(r_addr[csr_rd_addr[3:0]], r_cfg[csr_rd_addr[3:0]].mode);
      end
`ifdef PMP_SMEPMP_EN
      else if (csr_rd_addr == MSECCFG_ADDR) begin
         csr_rd_hit  = 1'b1;
         csr_rd_data = {29'b0, w_mseccfg};
      end
`endif
   end

   for (genvar g = 0; g < NE; g++) begin : g_out
      assign pmp_pmpcfg[g]  = r_cfg[g];
      assign pmp_pmpaddr[g] = r_addr[g];
   end

   assign csr_wr_ignored = r_wr_ignored;
   assign mseccfg        = w_mseccfg;

endmodule
